// File: rtl/seq_limb_mult.sv
// Sequential WIDTH x WIDTH multiplier built around one shared LIMB x LIMB unsigned multiplier.
// Limb partial products accumulate into a 2*WIDTH register. A signed result is corrected in a single FIX step.
module seq_limb_mult #(
    parameter int WIDTH = 64,
    parameter int LIMB  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    localparam int N     = WIDTH / LIMB;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int SH_W  = $clog2(2 * WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} state_t;

    state_t               state;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 signed_q;
    logic [2*WIDTH-1:0]   acc;
    logic [IDX_W-1:0]     i_q;
    logic [IDX_W-1:0]     j_q;

    logic [LIMB-1:0]      a_limb;
    logic [LIMB-1:0]      b_limb;
    logic [2*LIMB-1:0]    pp;
    logic [SH_W-1:0]      pp_shift;
    logic [2*WIDTH-1:0]   pp_wide;
    logic [2*WIDTH-1:0]   corr;
    logic [2*WIDTH-1:0]   fix_result;

    // Limbs are multiplied unsigned. The signed correction subtracts the operand weights of the two sign bits.
    always_comb begin
        a_limb     = LIMB'(a_q >> (SH_W'(i_q) * SH_W'(LIMB)));
        b_limb     = LIMB'(b_q >> (SH_W'(j_q) * SH_W'(LIMB)));
        pp         = {{LIMB{1'b0}}, a_limb} * {{LIMB{1'b0}}, b_limb};
        pp_shift   = (SH_W'(i_q) + SH_W'(j_q)) * SH_W'(LIMB);
        pp_wide    = (2*WIDTH)'(pp) << pp_shift;
        corr       = ((signed_q & a_q[WIDTH-1]) ? {b_q, {WIDTH{1'b0}}} : '0)
                   + ((signed_q & b_q[WIDTH-1]) ? {a_q, {WIDTH{1'b0}}} : '0);
        fix_result = signed_q ? (acc - corr) : acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_p     <= '0;
            acc       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            signed_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        signed_q <= in_signed;
                        acc      <= '0;
                        i_q      <= '0;
                        j_q      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    acc <= acc + pp_wide;
                    if (j_q == LAST) begin
                        j_q <= '0;
                        if (i_q == LAST) begin
                            state <= FIX;
                        end else begin
                            i_q <= i_q + IDX_W'(1);
                        end
                    end else begin
                        j_q <= j_q + IDX_W'(1);
                    end
                end
                FIX: begin
                    out_p     <= fix_result;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_limb_mult.sv
// Directed self-checking bench for seq_limb_mult: 64/16 main instance plus 16/16, 32/8 and 48/16 sweep instances.
module tb_seq_limb_mult;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic          in_valid, in_ready, in_signed, out_valid, out_ready, busy;
    logic [63:0]   in_a, in_b;
    logic [127:0]  out_p;

    logic          sw_in_valid, sw_out_ready, sw_in_signed;
    logic [47:0]   sw_a, sw_b;
    logic          r16, v16, b16, r32, v32, b32, r48, v48, b48;
    logic [31:0]   p16;
    logic [63:0]   p32;
    logic [95:0]   p48;

    int errors = 0;
    int checks = 0;

    seq_limb_mult #(.WIDTH(64), .LIMB(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .out_valid(out_valid),
        .out_ready(out_ready), .out_p(out_p), .busy(busy)
    );

    seq_limb_mult #(.WIDTH(16), .LIMB(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(r16),
        .in_a(sw_a[15:0]), .in_b(sw_b[15:0]), .in_signed(sw_in_signed), .out_valid(v16),
        .out_ready(sw_out_ready), .out_p(p16), .busy(b16)
    );

    seq_limb_mult #(.WIDTH(32), .LIMB(8)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(r32),
        .in_a(sw_a[31:0]), .in_b(sw_b[31:0]), .in_signed(sw_in_signed), .out_valid(v32),
        .out_ready(sw_out_ready), .out_p(p32), .busy(b32)
    );

    seq_limb_mult #(.WIDTH(48), .LIMB(16)) u48 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(r48),
        .in_a(sw_a), .in_b(sw_b), .in_signed(sw_in_signed), .out_valid(v48),
        .out_ready(sw_out_ready), .out_p(p48), .busy(b48)
    );

    // Reference product: extend each w-bit operand to 128 bits, multiply, keep 2*w bits.
    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                           input logic s, input int w);
        logic [127:0] m, ea, eb;
        m  = (128'd1 << w) - 128'd1;
        ea = {64'd0, a} & m;
        eb = {64'd0, b} & m;
        if (s && a[w-1]) ea = ea | ~m;
        if (s && b[w-1]) eb = eb | ~m;
        m  = (128'd1 << (2 * w)) - 128'd1;
        return (ea * eb) & m;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; returns the cycle number of the accepting edge.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic s, output int acc_cycle);
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_valid  = 1'b1;
        acc_cycle = -1;
        for (int k = 0; k < 100; k++) begin
            if (in_ready) begin
                @(posedge clk);
                @(negedge clk);
                acc_cycle = cycle;
                break;
            end
            @(negedge clk);
        end
        if (acc_cycle < 0) checkOutput("accept_timeout", 128'd0, 128'd1);
    endtask

    task automatic waitOutput(output int v_cycle, output int busy_cnt);
        v_cycle  = -1;
        busy_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            if (out_valid) begin
                v_cycle = cycle;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        if (v_cycle < 0) checkOutput("valid_timeout", 128'd0, 128'd1);
    endtask

    task automatic runOne(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic [127:0] exp_p);
        int ac, vc, bc;
        out_ready = 1'b1;
        applyStimulus(a, b, s, ac);
        in_valid = 1'b0;
        waitOutput(vc, bc);
        checkOutput({tag, "_p"}, out_p, exp_p);
        checkOutput({tag, "_lat"}, 128'(vc - ac), 128'd17);
        @(negedge clk);
        checkOutput({tag, "_handshake"}, {126'd0, out_valid, in_ready}, 128'b01);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] ra, rb;
        logic        rs;
        logic [47:0] va[12], vb[12];
        logic        vs[12];
        int ac, vc, bc, prev, l16, l32, l48;

        rst_n = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
        sw_in_valid = 1'b0; sw_out_ready = 1'b0; sw_a = '0; sw_b = '0; sw_in_signed = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_in_ready", {127'd0, in_ready}, 128'd1);
        checkOutput("rst_out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("rst_busy", {127'd0, busy}, 128'd0);
        checkOutput("rst_out_p", out_p, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned max*max; operands changed mid-operation must be ignored, then back-pressure.
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, ac);
        in_a = 64'hFFFF_FFFF_FFFF_FFFD; in_b = 64'd5; in_signed = 1'b1;
        waitOutput(vc, bc);
        checkOutput("umax_p", out_p, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        checkOutput("umax_lat", 128'(vc - ac), 128'd17);
        checkOutput("umax_busy_cycles", 128'(bc), 128'd17);
        checkOutput("umax_busy_low", {127'd0, busy}, 128'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("bp_p", out_p, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
            checkOutput("bp_flags", {125'd0, out_valid, in_ready, busy}, 128'b100);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release", {126'd0, out_valid, in_ready}, 128'b01);
        @(negedge clk);
        checkOutput("bp_single_handshake", {126'd0, out_valid, in_ready}, 128'b01);

        runOne("signed_m3x5", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
        runOne("unsigned_m3x5", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b0, 128'h0000_0000_0000_0004_FFFF_FFFF_FFFF_FFF1);
        runOne("signed_min_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
        runOne("signed_m1_m1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'd1);
        runOne("signed_zero", 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b1, 128'd0);
        runOne("signed_max_m1", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0001);

        // Reset during the seventh MUL cycle drops the transaction.
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, ac);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_flags", {125'd0, in_ready, out_valid, busy}, 128'b100);
        checkOutput("midrst_out_p", out_p, 128'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("midrst_no_valid", {126'd0, out_valid, in_ready}, 128'b01);
        runOne("after_reset", 64'd2, 64'd3, 1'b0, 128'd6);

        // Streaming with in_valid and out_ready held high.
        out_ready = 1'b1;
        prev = -1;
        for (int t = 0; t < 100; t++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = (t % 2 == 1);
            applyStimulus(ra, rb, rs, ac);
            if (t > 0) checkOutput($sformatf("stream_ii_%0d", t), 128'(ac - prev), 128'd19);
            prev = ac;
            waitOutput(vc, bc);
            checkOutput($sformatf("stream_p_%0d", t), out_p, model(ra, rb, rs, 64));
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Parameter sweep across three geometries in lockstep.
        va[0] = 48'h0;              vb[0] = 48'hFFFF_FFFF_FFFF; vs[0] = 1'b0;
        va[1] = 48'h1;              vb[1] = 48'hFFFF_FFFF_FFFF; vs[1] = 1'b1;
        va[2] = 48'hFFFF_FFFF_FFFF; vb[2] = 48'hFFFF_FFFF_FFFF; vs[2] = 1'b0;
        va[3] = 48'hFFFF_FFFF_FFFF; vb[3] = 48'hFFFF_FFFF_FFFF; vs[3] = 1'b1;
        va[4] = 48'h8000_8000_8000; vb[4] = 48'h8000_8000_8000; vs[4] = 1'b1;
        va[5] = 48'h0000_8000_0000; vb[5] = 48'h0000_8000_0000; vs[5] = 1'b1;
        va[6] = 48'h8000_0000_0000; vb[6] = 48'h7FFF_FFFF_FFFF; vs[6] = 1'b1;
        va[7] = 48'h8000_8000_8000; vb[7] = 48'h2;              vs[7] = 1'b0;
        for (int k = 8; k < 12; k++) begin
            va[k] = {$urandom, $urandom};
            vb[k] = {$urandom, $urandom};
            vs[k] = (k % 2 == 0);
        end
        for (int v = 0; v < 12; v++) begin
            sw_a = va[v]; sw_b = vb[v]; sw_in_signed = vs[v];
            sw_in_valid = 1'b1;
            sw_out_ready = 1'b0;
            checkOutput("sw_ready", {125'd0, r16, r32, r48}, 128'b111);
            @(posedge clk);
            @(negedge clk);
            ac = cycle;
            sw_in_valid = 1'b0;
            l16 = -1; l32 = -1; l48 = -1;
            for (int k = 0; k < 40; k++) begin
                if (v16 && l16 < 0) l16 = cycle - ac;
                if (v32 && l32 < 0) l32 = cycle - ac;
                if (v48 && l48 < 0) l48 = cycle - ac;
                if (l16 >= 0 && l32 >= 0 && l48 >= 0) break;
                @(negedge clk);
            end
            checkOutput($sformatf("sw16_p_%0d", v), {96'd0, p16}, model({48'd0, va[v]}, {48'd0, vb[v]}, vs[v], 16));
            checkOutput($sformatf("sw32_p_%0d", v), {64'd0, p32}, model({48'd0, va[v]}, {48'd0, vb[v]}, vs[v], 32));
            checkOutput($sformatf("sw48_p_%0d", v), {32'd0, p48}, model({16'd0, va[v]}, {16'd0, vb[v]}, vs[v], 48));
            checkOutput($sformatf("sw16_lat_%0d", v), 128'(l16), 128'd2);
            checkOutput($sformatf("sw32_lat_%0d", v), 128'(l32), 128'd17);
            checkOutput($sformatf("sw48_lat_%0d", v), 128'(l48), 128'd10);
            sw_out_ready = 1'b1;
            @(negedge clk);
            sw_out_ready = 1'b0;
            checkOutput("sw_handshake", {122'd0, v16, v32, v48, r16, r32, r48}, 128'b000111);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
